// File: rtl/sketch_pkg.sv
// -----------------------------------------------------------------------------
// sketch_pkg
// Shared types and constants for the etch-a-sketch pixel source.
//   - ILI9341_color_t : RGB565 pixel colour as consumed by the ILI9341 controller
//   - ILI9341_*       : the controller's basic colour codes
//   - INK/PAPER/CURSOR_COLOR : the three colours the sketch can show
//   - sketch_state_t  : top-level FSM states (erasing / running)
// -----------------------------------------------------------------------------
package sketch_pkg;

    typedef logic [15:0] ILI9341_color_t;

    localparam ILI9341_color_t ILI9341_BLACK = 16'h0000;
    localparam ILI9341_color_t ILI9341_WHITE = 16'hFFFF;
    localparam ILI9341_color_t ILI9341_RED   = 16'hF800;

    localparam ILI9341_color_t INK_COLOR    = ILI9341_BLACK;
    localparam ILI9341_color_t PAPER_COLOR  = ILI9341_WHITE;
    localparam ILI9341_color_t CURSOR_COLOR = ILI9341_RED;

    typedef enum logic {
        S_CLEAR = 1'b0,
        S_RUN   = 1'b1
    } sketch_state_t;

endpackage

// File: rtl/sketch_bitmap_ram.sv
// -----------------------------------------------------------------------------
// sketch_bitmap_ram
// Simple synchronous dual-port RAM holding the ink bitmap: one write port, one
// read port, one-cycle read latency, old data returned on a same-address
// read/write collision. No reset: contents are defined by the owner's clear pass.
// Ports:
//   clk      in   clock
//   i_we     in   write enable
//   i_waddr  in   write address
//   i_wdata  in   write data (W bits)
//   i_raddr  in   read address
//   o_rdata  out  read data, valid one cycle after i_raddr
// -----------------------------------------------------------------------------
module sketch_bitmap_ram #(
    parameter int W = 1,
    parameter int L = 4800
) (
    input  logic                 clk,
    input  logic                 i_we,
    input  logic [$clog2(L)-1:0] i_waddr,
    input  logic [W-1:0]         i_wdata,
    input  logic [$clog2(L)-1:0] i_raddr,
    output logic [W-1:0]         o_rdata
);

    logic [W-1:0] r_mem [L];

    // NOTE: storage arrays are deliberately left without a reset so they map
    // onto block RAM; the top-level clear pass defines their contents.
    always_ff @(posedge clk) begin
        if (i_we) begin
            r_mem[i_waddr] <= i_wdata;
        end
        // Non-blocking read of the array gives read-before-write on collision.
        o_rdata <= r_mem[i_raddr];
    end

endmodule

// File: rtl/sketch_pixel_source.sv
// -----------------------------------------------------------------------------
// sketch_pixel_source
// Pixel producer for the ILI9341 etch-a-sketch. Keeps a coarse 1-bit bitmap of
// inked cells and a cursor driven by debounced button pulses, inks the cursor
// cell while the pen is down, and streams one RGB565 colour per display pixel
// in raster order (x fastest) over a valid/ready handshake.
//
// Optional feature macro: SKETCH_CURSOR_BLINK_EN
//   defined   : cursor blinks, toggling every BLINK_FRAMES frames
//   undefined : cursor always visible
//
// Ports:
//   clk, rstb                 clock, asynchronous active-low reset
//   move_left/right/up/down   1-cycle cursor move pulses (saturating)
//   pen_down                  level: ink the cursor cell every running cycle
//   clear                     1-cycle pulse: erase the bitmap
//   o_ready                   consumer accepts the presented pixel
//   o_valid, o_data           pixel stream handshake and RGB565 colour
//   o_sof, o_eol, o_eof       first pixel / last pixel of row / last of frame
//   cursor_x, cursor_y        cursor cell coordinates
//   busy                      high while the bitmap is being erased
// -----------------------------------------------------------------------------
module sketch_pixel_source
    import sketch_pkg::*;
#(
    parameter int DISPLAY_WIDTH  = 240,
    parameter int DISPLAY_HEIGHT = 320,
    parameter int CELL_LOG2      = 2
`ifdef SKETCH_CURSOR_BLINK_EN
    ,
    parameter int BLINK_FRAMES   = 16
`endif
) (
    input  logic                                            clk,
    input  logic                                            rstb,
    input  logic                                            move_left,
    input  logic                                            move_right,
    input  logic                                            move_up,
    input  logic                                            move_down,
    input  logic                                            pen_down,
    input  logic                                            clear,
    input  logic                                            o_ready,
    output logic                                            o_valid,
    output logic [15:0]                                     o_data,
    output logic                                            o_sof,
    output logic                                            o_eol,
    output logic                                            o_eof,
    output logic [$clog2(DISPLAY_WIDTH >> CELL_LOG2)-1:0]   cursor_x,
    output logic [$clog2(DISPLAY_HEIGHT >> CELL_LOG2)-1:0]  cursor_y,
    output logic                                            busy
);

    localparam int CELLS_X = DISPLAY_WIDTH >> CELL_LOG2;
    localparam int CELLS_Y = DISPLAY_HEIGHT >> CELL_LOG2;
    localparam int CELLS   = CELLS_X * CELLS_Y;
    localparam int XW      = $clog2(CELLS_X);
    localparam int YW      = $clog2(CELLS_Y);
    localparam int AW      = $clog2(CELLS);
    localparam int PXW     = $clog2(DISPLAY_WIDTH);
    localparam int PYW     = $clog2(DISPLAY_HEIGHT);

    localparam logic [XW-1:0]  CUR_X_MAX = XW'(CELLS_X - 1);
    localparam logic [YW-1:0]  CUR_Y_MAX = YW'(CELLS_Y - 1);
    localparam logic [XW-1:0]  CUR_X_RST = XW'(CELLS_X / 2);
    localparam logic [YW-1:0]  CUR_Y_RST = YW'(CELLS_Y / 2);
    localparam logic [PXW-1:0] PX_LAST   = PXW'(DISPLAY_WIDTH - 1);
    localparam logic [PYW-1:0] PY_LAST   = PYW'(DISPLAY_HEIGHT - 1);
    localparam logic [AW-1:0]  CLR_LAST  = AW'(CELLS - 1);

    // FSM and clear sweep
    sketch_state_t   r_state, w_state_nxt;
    logic [AW-1:0]   r_clr_addr, w_clr_addr_nxt;
    logic            w_clr_done;

    // Bitmap ports
    logic            w_ram_we;
    logic [AW-1:0]   w_ram_waddr;
    logic            w_ram_wdata;
    logic [AW-1:0]   w_ram_raddr;
    logic            w_ram_rdata;

    // Cursor
    logic [XW-1:0]   r_cur_x, w_cur_x_nxt;
    logic [YW-1:0]   r_cur_y, w_cur_y_nxt;
    logic [AW-1:0]   w_cur_addr;
    logic            w_cursor_vis;
    logic            w_cursor_hit;

    // Stream
    logic [PXW-1:0]  r_px, w_px_nxt;
    logic [PYW-1:0]  r_py, w_py_nxt;
    logic            r_valid;
    logic            r_stall;
    ILI9341_color_t  r_hold;
    ILI9341_color_t  w_pix_color;
    ILI9341_color_t  w_color;
    logic            w_xfer;

    // -------------------------------------------------------------------------
    // Cursor movement: opposite pulses cancel, each axis saturates.
    // -------------------------------------------------------------------------
    // NOTE: every signal written in a combinational block gets a default at the
    // top so no path leaves it unassigned (which would infer a latch).
    always_comb begin
        w_cur_x_nxt = r_cur_x;
        w_cur_y_nxt = r_cur_y;
        if (r_state == S_RUN) begin
            if (move_left && !move_right && r_cur_x != '0) begin
                w_cur_x_nxt = r_cur_x - 1'b1;
            end else if (move_right && !move_left && r_cur_x != CUR_X_MAX) begin
                w_cur_x_nxt = r_cur_x + 1'b1;
            end
            if (move_up && !move_down && r_cur_y != '0) begin
                w_cur_y_nxt = r_cur_y - 1'b1;
            end else if (move_down && !move_up && r_cur_y != CUR_Y_MAX) begin
                w_cur_y_nxt = r_cur_y + 1'b1;
            end
        end
    end

    // Pen ink lands on the post-move cursor cell.
    assign w_cur_addr = AW'(w_cur_y_nxt) * AW'(CELLS_X) + AW'(w_cur_x_nxt);

    // -------------------------------------------------------------------------
    // FSM next state, clear sweep and bitmap write port
    // -------------------------------------------------------------------------
    always_comb begin
        w_state_nxt    = r_state;
        w_clr_addr_nxt = r_clr_addr;
        w_ram_we       = 1'b0;
        w_ram_waddr    = r_clr_addr;
        w_ram_wdata    = 1'b0;
        case (r_state)
            S_CLEAR: begin
                w_ram_we = 1'b1;
                if (clear) begin
                    w_clr_addr_nxt = '0;
                end else if (r_clr_addr == CLR_LAST) begin
                    w_state_nxt = S_RUN;
                end else begin
                    w_clr_addr_nxt = r_clr_addr + 1'b1;
                end
            end
            S_RUN: begin
                if (clear) begin
                    w_state_nxt    = S_CLEAR;
                    w_clr_addr_nxt = '0;
                end else if (pen_down) begin
                    w_ram_we    = 1'b1;
                    w_ram_waddr = w_cur_addr;
                    w_ram_wdata = 1'b1;
                end
            end
            default: begin
                w_state_nxt = S_CLEAR;
            end
        endcase
    end

    assign w_clr_done = (r_state == S_CLEAR) && (r_clr_addr == CLR_LAST) && !clear;
    assign busy       = (r_state == S_CLEAR);

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge rstb) begin
        if (!rstb) begin
            r_state    <= S_CLEAR;
            r_clr_addr <= '0;
        end else begin
            r_state    <= w_state_nxt;
            r_clr_addr <= w_clr_addr_nxt;
        end
    end

    // -------------------------------------------------------------------------
    // Stream pointer. The RAM is addressed with the pixel that will be
    // presented next cycle, hiding its one-cycle read latency.
    // -------------------------------------------------------------------------
    assign w_xfer = r_valid && o_ready;

    always_comb begin
        w_px_nxt = r_px;
        w_py_nxt = r_py;
        if (w_xfer) begin
            if (r_px == PX_LAST) begin
                w_px_nxt = '0;
                w_py_nxt = (r_py == PY_LAST) ? '0 : r_py + 1'b1;
            end else begin
                w_px_nxt = r_px + 1'b1;
            end
        end
    end

    assign w_ram_raddr = AW'(w_py_nxt >> CELL_LOG2) * AW'(CELLS_X)
                       + AW'(w_px_nxt >> CELL_LOG2);

    sketch_bitmap_ram #(
        .W (1),
        .L (CELLS)
    ) u_bitmap (
        .clk     (clk),
        .i_we    (w_ram_we),
        .i_waddr (w_ram_waddr),
        .i_wdata (w_ram_wdata),
        .i_raddr (w_ram_raddr),
        .o_rdata (w_ram_rdata)
    );

    // -------------------------------------------------------------------------
    // Cursor visibility
    // -------------------------------------------------------------------------
`ifdef SKETCH_CURSOR_BLINK_EN
    localparam int FW = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
    localparam logic [FW-1:0] FRAME_LAST = FW'(BLINK_FRAMES - 1);

    logic [FW-1:0] r_frame_cnt;
    logic          r_cursor_vis;

    // Toggling on the o_eof transfer means the new visibility first applies
    // to pixel (0,0) of the following frame.
    always_ff @(posedge clk or negedge rstb) begin
        if (!rstb) begin
            r_frame_cnt  <= '0;
            r_cursor_vis <= 1'b1;
        end else if (w_xfer && o_eof) begin
            if (r_frame_cnt == FRAME_LAST) begin
                r_frame_cnt  <= '0;
                r_cursor_vis <= !r_cursor_vis;
            end else begin
                r_frame_cnt <= r_frame_cnt + 1'b1;
            end
        end
    end

    assign w_cursor_vis = r_cursor_vis;
`else
    assign w_cursor_vis = 1'b1;
`endif

    // -------------------------------------------------------------------------
    // Pixel colour and output hold. While stalled the first computed colour is
    // replayed so cursor moves or pen writes cannot disturb a presented pixel.
    // -------------------------------------------------------------------------
    assign w_cursor_hit = (XW'(r_px >> CELL_LOG2) == r_cur_x)
                       && (YW'(r_py >> CELL_LOG2) == r_cur_y);

    always_comb begin
        w_pix_color = PAPER_COLOR;
        if (w_cursor_hit && w_cursor_vis) begin
            w_pix_color = CURSOR_COLOR;
        end else if (w_ram_rdata) begin
            w_pix_color = INK_COLOR;
        end
    end

    assign w_color = r_stall ? r_hold : w_pix_color;

    always_ff @(posedge clk or negedge rstb) begin
        if (!rstb) begin
            r_cur_x <= CUR_X_RST;
            r_cur_y <= CUR_Y_RST;
            r_px    <= '0;
            r_py    <= '0;
            r_valid <= 1'b0;
            r_stall <= 1'b0;
            r_hold  <= '0;
        end else begin
            r_cur_x <= w_cur_x_nxt;
            r_cur_y <= w_cur_y_nxt;
            r_px    <= w_px_nxt;
            r_py    <= w_py_nxt;
            // Sticky: later clears leave the stream running.
            if (w_clr_done) begin
                r_valid <= 1'b1;
            end
            r_stall <= r_valid && !o_ready;
            r_hold  <= w_color;
        end
    end

    assign o_valid  = r_valid;
    assign o_data   = r_valid ? w_color : 16'h0000;
    assign o_sof    = r_valid && (r_px == '0) && (r_py == '0);
    assign o_eol    = r_valid && (r_px == PX_LAST);
    assign o_eof    = r_valid && (r_px == PX_LAST) && (r_py == PY_LAST);
    assign cursor_x = r_cur_x;
    assign cursor_y = r_cur_y;

endmodule
